// File: rtl/fifo_req_initiator.sv
// fifo_req_initiator: initiator side of the FIFO push/pop req/ack protocol.
// Requests and their data are held until ack. Popped data is captured one
// cycle after pop_ack. Per-side timeouts are sticky. occ tracks acked pushes
// minus acked pops.
// Optional build macro FIFO_FLAG_GATE_EN: defer raising new requests while
// the FIFO reports full (push) or empty (pop).
module fifo_req_initiator #(
  parameter int WIDTH      = 8,
  parameter int L2D        = 4,
  parameter int TMO_CYCLES = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             push_req,
  input  logic             push_ack,
  output logic [WIDTH-1:0] data_in,
  output logic             pop_req,
  input  logic             pop_ack,
  input  logic [WIDTH-1:0] data_out,
  input  logic             full,
  input  logic             empty,
  input  logic             tmo_clr,
  output logic             push_tmo,
  output logic             pop_tmo,
  output logic [L2D:0]     occ
);
  localparam int         OW  = L2D + 1;
  localparam logic [7:0] TMO = 8'(TMO_CYCLES);

  typedef enum logic [1:0] {Q_IDLE, Q_REQ, Q_CAPT} pop_state_t;

  pop_state_t state, state_d;
  logic       push_xfer, pop_xfer;
  logic       push_stall, pop_stall;
  logic       push_tmo_set, pop_tmo_set;
  logic [7:0] push_cnt, pop_cnt;

  assign push_xfer  = push_req && push_ack;
  assign pop_xfer   = pop_req && pop_ack;
  assign push_stall = push_req && !push_ack;
  assign pop_stall  = pop_req && !pop_ack;

`ifdef FIFO_FLAG_GATE_EN
  // A full FIFO blocks new pushes; an already raised push_req is unaffected.
  assign wr_ready = (!push_req || push_ack) && !full;
  logic rd_pend, rd_pend_d;
`else
  assign wr_ready = !push_req || push_ack;
  logic unused_flags;
  assign unused_flags = full ^ empty;
`endif

  // Push side: load on accept, hold while stalled, release on ack with no new word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      push_req <= 1'b0;
      data_in  <= '0;
    end else if (wr_valid && wr_ready) begin
      push_req <= 1'b1;
      data_in  <= wr_data;
    end else if (push_xfer) begin
      push_req <= 1'b0;
    end
  end

  // Pop FSM next-state and client-side ready.
  always_comb begin
    state_d  = state;
    rd_ready = 1'b0;
`ifdef FIFO_FLAG_GATE_EN
    rd_pend_d = rd_pend;
`endif
    case (state)
      Q_IDLE: begin
`ifdef FIFO_FLAG_GATE_EN
        rd_ready = !rd_pend;
        if ((rd_req || rd_pend) && !empty) begin
          state_d   = Q_REQ;
          rd_pend_d = 1'b0;
        end else if (rd_req) begin
          rd_pend_d = 1'b1;
        end
`else
        rd_ready = 1'b1;
        if (rd_req) state_d = Q_REQ;
`endif
      end
      Q_REQ:   if (pop_ack) state_d = Q_CAPT;
      Q_CAPT:  state_d = Q_IDLE;
      default: state_d = Q_IDLE;
    endcase
  end

  // Pop FSM state, pop_req, and one-cycle capture of data_out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= Q_IDLE;
      pop_req  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef FIFO_FLAG_GATE_EN
      rd_pend  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      pop_req  <= (state_d == Q_REQ);
      rd_valid <= (state == Q_CAPT);
      if (state == Q_CAPT) rd_data <= data_out;
`ifdef FIFO_FLAG_GATE_EN
      rd_pend  <= rd_pend_d;
`endif
    end
  end

  // Flag sets on the edge where the counter reaches TMO, and stays set
  // while the stall continues at saturation.
  assign push_tmo_set = push_stall && (push_cnt >= TMO - 8'd1);
  assign pop_tmo_set  = pop_stall  && (pop_cnt  >= TMO - 8'd1);

  // Saturating stall counters; cleared on ack or when no request is up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      push_cnt <= !push_stall ? 8'd0 : (push_cnt >= TMO) ? TMO : push_cnt + 8'd1;
      pop_cnt  <= !pop_stall  ? 8'd0 : (pop_cnt  >= TMO) ? TMO : pop_cnt  + 8'd1;
    end
  end

  // Sticky timeout flags; set beats clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      push_tmo <= 1'b0;
      pop_tmo  <= 1'b0;
    end else begin
      if (push_tmo_set)  push_tmo <= 1'b1;
      else if (tmo_clr)  push_tmo <= 1'b0;
      if (pop_tmo_set)   pop_tmo  <= 1'b1;
      else if (tmo_clr)  pop_tmo  <= 1'b0;
    end
  end

  // Occupancy estimate; wrap is left visible as a protocol violation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) occ <= '0;
    else         occ <= occ + OW'(push_xfer) - OW'(pop_xfer);
  end
endmodule
